alu_mul_sequencer: RTL
======================

# alu_mul_sequencer

Iterative 32x32→64 multiply controller for the SPARC V8 integer unit. It borrows the shared combinational `alu` and drives it through a fixed sequence of ADDcc, SUBcc and SUBXcc operations to implement UMUL, SMUL, UMULcc and SMULcc. The low word goes to rd and the high word to Y. While the sequencer owns the ALU, the integer pipeline stalls on `busy` and the ALU input mux selects the sequencer via `alu_sel`.

## Interface
Parameters:
- `STEPS`, 32, number of shift-add iterations; fixed at 32 for V8.

Ports:
- `clk`, in, 1, rising-edge clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, request a multiply; sampled only in IDLE.
- `signed_op`, in, 1, 1 = SMUL/SMULcc, 0 = UMUL/UMULcc; sampled with `start`.
- `setcc`, in, 1, cc variant; sampled with `start`.
- `a`, in, 32, multiplicand rs1; sampled with `start`.
- `b`, in, 32, multiplier rs2/simm; sampled with `start`.
- `alu_res`, in, 32, ALU result.
- `alu_c`, in, 1, ALU C flag.
- `alu_op`, out, 6, ALU opcode.
- `alu_a`, out, 32, ALU operand a.
- `alu_b`, out, 32, ALU operand b.
- `alu_cin`, out, 1, ALU carry-in.
- `alu_sel`, out, 1, 1 = sequencer owns the ALU.
- `busy`, out, 1, pipeline stall request.
- `done`, out, 1, one-cycle completion pulse.
- `prod_lo`, out, 32, product bits [31:0] for rd.
- `y_out`, out, 32, product bits [63:32] for Y.
- `icc_n`, `icc_z`, `icc_v`, `icc_c`, out, 1 each, condition codes.
- `icc_we`, out, 1, icc write strobe; equals `done & setcc_r`.

## Operation
- Opcodes:
  - ADDcc = 6'b010000.
  - SUBcc = 6'b010100.
  - SUBXcc = 6'b011100.
  - Carry C on subtract is borrow.
- States: IDLE, ABS_A, ABS_B, STEP, NEG_LO, NEG_HI, DONE.
- Registers:
  - `mcand` (32).
  - `acc_hi` and `acc_lo` (32 each).
  - `cnt` (6).
  - `neg_r` = a[31]^b[31] when signed, else 0.
  - `borrow_r`, `setcc_r`.
- IDLE with start=1:
  - Latch the sampled inputs.
  - Unsigned: mcand←a, acc_lo←b, acc_hi←0, cnt←0, go to STEP.
  - Signed: go to ABS_A.
- ABS_A: drive alu_a=0, alu_b=a_r, SUBcc. mcand←a_r[31] ? alu_res : a_r.
- ABS_B: drive alu_a=0, alu_b=b_r, SUBcc. acc_lo←b_r[31] ? alu_res : b_r, acc_hi←0, cnt←0.
- STEP:
  - Drive alu_a=acc_hi, alu_b=acc_lo[0] ? mcand : 0, alu_cin=0, ADDcc.
  - Update acc_hi←{alu_c, alu_res[31:1]}, acc_lo←{alu_res[0], acc_lo[31:1]}, cnt←cnt+1.
  - Exit after the 32nd step: signed→NEG_LO, unsigned→DONE.
- NEG_LO: drive alu_a=0, alu_b=acc_lo, SUBcc. borrow_r←alu_c. If neg_r, acc_lo←alu_res.
- NEG_HI: drive alu_a=0, alu_b=acc_hi, alu_cin=borrow_r, SUBXcc. If neg_r, acc_hi←alu_res. Go to DONE.
- DONE:
  - prod_lo←acc_lo, y_out←acc_hi.
  - icc_n←acc_lo[31], icc_z←(acc_lo==0), icc_v←0, icc_c←0. The icc registers update only when setcc_r.
  - done=1, then return to IDLE.
- Output qualification:
  - `alu_sel` and `busy` = state ∉ {IDLE, DONE}.
  - In IDLE/DONE, alu_op/alu_a/alu_b/alu_cin drive 0.
- start in any state other than IDLE is ignored. No queuing.
- a=0x80000000 (signed): abs yields 0x80000000 and is treated as unsigned 2^31. The result must still be correct.

## Timing
- Reset (async, rst_n=0): state IDLE. All registers and outputs 0: prod_lo, y_out, icc_*, done, busy, alu_sel, alu_*.
- Reset mid-operation: abort immediately, no done pulse, prod_lo/y_out cleared.
- Start accepted at edge E0; busy rises after E0.
- Unsigned: 32 STEP cycles, done high in the cycle after edge E0+32.
- Signed: 36 busy cycles, done high in the cycle after edge E0+36.
- done and icc_we are high exactly one cycle. Earliest next start is accepted at the edge ending DONE+1, i.e. IDLE.
- prod_lo, y_out and icc_* are registered and hold until the next completion or reset.
- The ALU is combinational. The sequencer samples alu_res/alu_c at the same edge it drives the operands.

## Test plan
- Unsigned 0xFFFFFFFF×0xFFFFFFFF, setcc=1 → after 32 cycles: y_out=0xFFFFFFFE, prod_lo=0x00000001, N=0 Z=0 V=0 C=0, icc_we one pulse.
- Signed −3×7, setcc=1 → after 36 cycles: y_out=0xFFFFFFFF, prod_lo=0xFFFFFFEB, N=1 Z=0.
- Signed 0x80000000×0x80000000 → y_out=0x40000000, prod_lo=0, Z=1 N=0.
- Unsigned 0×0x12345678, setcc=0 → product 0, icc unchanged from its prior value, icc_we=0, done pulses.
- start reasserted with different operands during STEP 5 → ignored; the original product completes at the original cycle.
- rst_n pulsed low during STEP 10 → busy, alu_sel and all outputs 0 immediately; no done. A new start after release completes normally.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Iterative 32x32->64 multiply controller that borrows the shared integer ALU
// for shift-add steps, plus abs/negate fix-ups for signed operands.
module alu_mul_sequencer #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic        setcc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] alu_res,
  input  logic        alu_c,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic        alu_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod_lo,
  output logic [31:0] y_out,
  output logic        icc_n,
  output logic        icc_z,
  output logic        icc_v,
  output logic        icc_c,
  output logic        icc_we
);

  localparam logic [5:0] OP_ADDCC  = 6'b010000;
  localparam logic [5:0] OP_SUBCC  = 6'b010100;
  localparam logic [5:0] OP_SUBXCC = 6'b011100;
  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  typedef enum logic [2:0] {
    IDLE, ABS_A, ABS_B, STEP, NEG_LO, NEG_HI, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] a_r, b_r, mcand, acc_hi, acc_lo;
  logic [31:0] mcand_nxt, acc_hi_nxt, acc_lo_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic        neg_r, borrow_r, setcc_r, signed_r;
  logic        borrow_nxt, finishing;

  always_comb begin
    state_nxt  = state;
    alu_op     = 6'd0;
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    alu_cin    = 1'b0;
    mcand_nxt  = mcand;
    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    cnt_nxt    = cnt;
    borrow_nxt = borrow_r;
    case (state)
      IDLE: begin
        if (start) begin
          if (signed_op) begin
            state_nxt = ABS_A;
          end else begin
            mcand_nxt  = a;
            acc_lo_nxt = b;
            acc_hi_nxt = 32'd0;
            cnt_nxt    = 6'd0;
            state_nxt  = STEP;
          end
        end
      end
      ABS_A: begin
        alu_op    = OP_SUBCC;
        alu_b     = a_r;
        mcand_nxt = a_r[31] ? alu_res : a_r;
        state_nxt = ABS_B;
      end
      ABS_B: begin
        alu_op     = OP_SUBCC;
        alu_b      = b_r;
        acc_lo_nxt = b_r[31] ? alu_res : b_r;
        acc_hi_nxt = 32'd0;
        cnt_nxt    = 6'd0;
        state_nxt  = STEP;
      end
      STEP: begin
        // Carry-out of the add becomes the top bit shifted into acc_hi.
        alu_op     = OP_ADDCC;
        alu_a      = acc_hi;
        alu_b      = acc_lo[0] ? mcand : 32'd0;
        acc_hi_nxt = {alu_c, alu_res[31:1]};
        acc_lo_nxt = {alu_res[0], acc_lo[31:1]};
        cnt_nxt    = cnt + 6'd1;
        if (cnt == LAST_STEP) begin
          state_nxt = signed_r ? NEG_LO : DONE;
        end
      end
      NEG_LO: begin
        alu_op     = OP_SUBCC;
        alu_b      = acc_lo;
        borrow_nxt = alu_c;
        if (neg_r) begin
          acc_lo_nxt = alu_res;
        end
        state_nxt = NEG_HI;
      end
      NEG_HI: begin
        alu_op  = OP_SUBXCC;
        alu_b   = acc_hi;
        alu_cin = borrow_r;
        if (neg_r) begin
          acc_hi_nxt = alu_res;
        end
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Results load on the edge entering DONE so they are valid alongside done.
  assign finishing = (state != DONE) && (state_nxt == DONE);
  assign busy      = (state != IDLE) && (state != DONE);
  assign alu_sel   = busy;
  assign done      = (state == DONE);
  assign icc_we    = done & setcc_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      mcand    <= 32'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      cnt      <= 6'd0;
      neg_r    <= 1'b0;
      borrow_r <= 1'b0;
      setcc_r  <= 1'b0;
      signed_r <= 1'b0;
      prod_lo  <= 32'd0;
      y_out    <= 32'd0;
      icc_n    <= 1'b0;
      icc_z    <= 1'b0;
      icc_v    <= 1'b0;
      icc_c    <= 1'b0;
    end else begin
      state    <= state_nxt;
      mcand    <= mcand_nxt;
      acc_hi   <= acc_hi_nxt;
      acc_lo   <= acc_lo_nxt;
      cnt      <= cnt_nxt;
      borrow_r <= borrow_nxt;
      if (state == IDLE && start) begin
        a_r      <= a;
        b_r      <= b;
        setcc_r  <= setcc;
        signed_r <= signed_op;
        neg_r    <= signed_op & (a[31] ^ b[31]);
      end
      if (finishing) begin
        prod_lo <= acc_lo_nxt;
        y_out   <= acc_hi_nxt;
        if (setcc_r) begin
          icc_n <= acc_lo_nxt[31];
          icc_z <= (acc_lo_nxt == 32'd0);
          icc_v <= 1'b0;
          icc_c <= 1'b0;
        end
      end
    end
  end

endmodule
